// File: rtl/pipe_scheduler.sv
// Pipe obstacle sequencer: places, scrolls and respawns three pipes, flags bird passes.
// Optional macro SPEED_RAMP_EN: every 8th pass bumps the speed by one.
module pipe_scheduler #(
   parameter int TICK_DIV     = 100000,
   parameter int SCREEN_W     = 640,
   parameter int PIPE_SPACING = 220,
   parameter int PIPE_W       = 52,
   parameter int BIRD_X       = 160,
   parameter int GAP_MIN      = 80,
   parameter int SPEED_MIN    = 1,
   parameter int SPEED_MAX    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        pipe_up,
   input  logic        pipe_down,
   output logic [31:0] pipe1,
   output logic [31:0] pipe2,
   output logic [31:0] pipe3,
   output logic [3:0]  speed,
   output logic        tick,
   output logic        pass_pulse
);
   typedef enum logic [1:0] {IDLE, PLACE, RUN, FREEZE} state_t;

   localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [15:0]    RESPAWN  = 16'(3 * PIPE_SPACING);

   state_t           r_state;
   logic [1:0]       r_pidx;
   logic [CW-1:0]    r_cnt;
   logic [15:0]      r_lfsr;
   logic             r_up_q, r_dn_q;
   logic [3:0]       r_speed;
   logic             r_tick, r_pass;
   logic [2:0][15:0] r_x, r_gap;

   logic             w_fb;
   logic [15:0]      w_gap, w_spd16;
   logic [2:0][15:0] w_x_nxt, w_gap_nxt;
   logic             w_pass;
   logic             w_up_rise, w_dn_rise, w_ramp, w_dec;
   logic [1:0]       w_inc;
   logic [5:0]       w_spd_sum;
   logic [3:0]       w_spd_nxt;

   assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_gap   = 16'(GAP_MIN) + {8'd0, r_lfsr[7:0]};
   assign w_spd16 = {12'd0, r_speed};

   // Next positions for a scroll step; a pipe at or left of the step wraps to the far right.
   always_comb begin
      w_x_nxt   = r_x;
      w_gap_nxt = r_gap;
      w_pass    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (r_x[i] <= w_spd16) begin
            w_x_nxt[i]   = r_x[i] + RESPAWN - w_spd16;
            w_gap_nxt[i] = w_gap;
         end else begin
            w_x_nxt[i] = r_x[i] - w_spd16;
         end
         if ((r_x[i] + 16'(PIPE_W) >= 16'(BIRD_X)) &&
             (w_x_nxt[i] + 16'(PIPE_W) < 16'(BIRD_X)))
            w_pass = 1'b1;
      end
   end

   assign w_up_rise = pipe_up & ~r_up_q;
   assign w_dn_rise = pipe_down & ~r_dn_q;

`ifdef SPEED_RAMP_EN
   logic [2:0] r_pass_cnt;
   assign w_ramp = r_pass & (r_pass_cnt == 3'd7);
   always_ff @(posedge clk) begin
      if (rst)         r_pass_cnt <= 3'd0;
      else if (r_pass) r_pass_cnt <= r_pass_cnt + 3'd1;
   end
`else
   assign w_ramp = 1'b0;
`endif

   // Button and ramp contributions are summed first so a coincidence clamps once.
   always_comb begin
      w_inc     = {1'b0, w_up_rise & ~w_dn_rise} + {1'b0, w_ramp};
      w_dec     = w_dn_rise & ~w_up_rise;
      w_spd_sum = {2'b00, r_speed} + {4'd0, w_inc} - {5'd0, w_dec};
      if (w_spd_sum > 6'(SPEED_MAX))      w_spd_nxt = 4'(SPEED_MAX);
      else if (w_spd_sum < 6'(SPEED_MIN)) w_spd_nxt = 4'(SPEED_MIN);
      else                                w_spd_nxt = w_spd_sum[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_pidx  <= 2'd0;
         r_cnt   <= '0;
         r_lfsr  <= 16'hACE1;
         r_up_q  <= 1'b0;
         r_dn_q  <= 1'b0;
         r_speed <= 4'(SPEED_MIN);
         r_tick  <= 1'b0;
         r_pass  <= 1'b0;
         r_x     <= '0;
         r_gap   <= '0;
      end else begin
         r_lfsr  <= {w_fb, r_lfsr[15:1]};
         r_up_q  <= pipe_up;
         r_dn_q  <= pipe_down;
         r_speed <= w_spd_nxt;
         r_tick  <= 1'b0;
         r_pass  <= 1'b0;
         case (r_state)
            IDLE: if (run) begin
               r_state <= PLACE;
               r_pidx  <= 2'd0;
            end
            PLACE: begin
               r_x[r_pidx]   <= 16'(SCREEN_W) + 16'(r_pidx) * 16'(PIPE_SPACING);
               r_gap[r_pidx] <= w_gap;
               if (r_pidx == 2'd2) r_state <= RUN;
               else                r_pidx  <= r_pidx + 2'd1;
            end
            RUN: begin
               if (!run) begin
                  r_state <= FREEZE;
               end else if (r_cnt == CNT_LAST) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
                  r_pass <= w_pass;
                  r_x    <= w_x_nxt;
                  r_gap  <= w_gap_nxt;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            FREEZE: if (run) r_state <= RUN;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pipe1      = {r_x[0], r_gap[0]};
   assign pipe2      = {r_x[1], r_gap[1]};
   assign pipe3      = {r_x[2], r_gap[2]};
   assign speed      = r_speed;
   assign tick       = r_tick;
   assign pass_pulse = r_pass;
endmodule
